dsp_result_collector: RTL and testbench
=======================================

// Module: dsp_result_collector
// PURPOSE
//  Downstream stage of the DSP48A1 slice. Tracks each issued operation through the slice's fixed pipeline latency.
//  Captures P when that operation emerges, then rounds, shifts and saturates it to OUT_W bits.
//  Buffers results in a small FIFO with a valid/ready output. Credit-based in_ready keeps the slice free-running.
// PARAMETERS
//  P_W        48  width of slice P input
//  OUT_W      18  width of packed result, signed two's complement
//  SHIFT      0   arithmetic right shift applied to P (fixed-point scaling), 0..P_W-OUT_W
//  ROUND      1   1: round half-up (add 2^(SHIFT-1) before shift, only if SHIFT>0); 0: truncate
//  SAT        1   1: saturate to signed OUT_W range; 0: wrap (keep low OUT_W bits)
//  LAT        2   cycles from in_valid to matching P valid at p_in (slice register count), 1..8
//  DEPTH      4   FIFO entries, power of two, >=2
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        async active-low reset
//  in_valid     in   1        operation issued to slice this cycle (qualified by in_ready)
//  in_ready     out  1        space reserved for one more result
//  flush        in   1        sync: drop FIFO contents and all in-flight operations
//  p_in         in   P_W      slice P output (signed)
//  carryout_in  in   1        slice CARRYOUT, captured alongside P
//  out_valid    out  1        FIFO head valid
//  out_ready    in   1        consumer accepts head
//  out_data     out  OUT_W    packed result at head
//  out_cy       out  1        carryout captured with head
//  out_sat      out  1        head result was saturated/wrapped
//  ovf_sticky   out  1        any saturate/wrap since last clear
//  clr_sticky   in   1        sync clear of ovf_sticky
//  level        out  clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset (rst_n=0, async): FIFO empty, valid pipe 0, in_ready=1, out_valid=0, out_data=0, out_cy=0, out_sat=0, ovf_sticky=0, level=0.
//  Issue: accept = in_valid & in_ready. vpipe[0]<=accept; vpipe[k]<=vpipe[k-1]; the pipe always advances, with no stall.
//  Capture: on the edge where vpipe[LAT-1]=1, p_in/carryout_in are processed and pushed. accept at cycle t -> push at edge ending cycle t+LAT.
//  Latency: out_valid rises in cycle t+LAT+1 if the FIFO was empty. There is no bypass path.
//  Credit: inflight = popcount(vpipe). in_ready = (level + inflight) < DEPTH, registered-input combinational.
//    Consequence: a push never finds the FIFO full. Push+pop in the same cycle: level unchanged.
//  Arithmetic: r = sext(p_in, P_W+1) + (ROUND&&SHIFT>0 ? 2^(SHIFT-1) : 0), computed without overflow; s = r >>> SHIFT.
//    Negative ties round toward +inf (-1.5 -> -1).
//  SAT=1: s > 2^(OUT_W-1)-1 -> max; s < -2^(OUT_W-1) -> min; out_sat bit set for that entry.
//  SAT=0: low OUT_W bits are kept; out_sat set if s is not representable.
//  ovf_sticky: set on push of an entry with out_sat=1; clr_sticky clears it. Set wins when both happen in one cycle.
//  Pop: out_valid & out_ready. out_data/out_cy/out_sat reflect the head and hold stable while out_valid & !out_ready.
//  flush: on that edge level<=0 and vpipe<=0. A push or accept on the same cycle is dropped. in_ready=1 the next cycle.
//    ovf_sticky is unaffected.
//  Reset mid-operation: all in-flight results are discarded. No partial entry becomes visible.
// STRUCTURE
//  Shared package dsp_pkg holds: P_W/OUT_W defaults, sat_max/sat_min constants, function round_shift_sat(p, shift, round, sat)
//    returning {sat_flag, data}. The same function is reused by the scoreboard model.
//  Sub-module dsp_res_fifo: sync FIFO, width OUT_W+2, DEPTH entries, async active-low reset, flush input, level output.
//  Top holds: valid delay line, credit logic, arithmetic stage, sticky flag.
// TESTING
//  T1 latency: LAT=2, SHIFT=0, out_ready=1; in_valid pulse at cycle 5, p_in=0x1234 at cycle 7 -> out_valid in cycle 8, out_data=0x1234.
//  T2 rounding: SHIFT=4, ROUND=1; p_in=24 -> 2; p_in=-24 -> -1; p_in=23 -> 1. With ROUND=0: 24 -> 1, -24 -> -2.
//  T3 saturation: SHIFT=4, SAT=1; p_in=2^30 -> 0x1FFFF, out_sat=1, ovf_sticky=1. p_in=-2^30 -> 0x20000.
//    SAT=0, p_in=2^30 -> 0x00000, out_sat=1.
//  T4 backpressure: DEPTH=4, out_ready=0, in_valid held high 8 cycles -> exactly 4 accepts, then in_ready=0, level=4.
//    Release out_ready -> 4 pops in order, in_ready reasserts after the first pop.
//  T5 flush: 2 entries queued and 1 in flight, flush=1 -> next cycle level=0, out_valid=0. The in-flight P is never pushed.
//  T6 async reset: assert rst_n=0 mid-stream between clock edges -> outputs take reset values immediately.
//    After release, the first accept completes with T1 latency. Sticky set+clear in one cycle -> ovf_sticky=1.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP48A1 result collector: default widths, saturation
// limits and the round/shift/saturate helper used by the collector datapath.
package dsp_pkg;

    localparam int DSP_P_W   = 48;
    localparam int DSP_OUT_W = 18;
    localparam int CALC_W    = 65;

    localparam logic signed [DSP_OUT_W-1:0] SAT_MAX = {1'b0, {(DSP_OUT_W-1){1'b1}}};
    localparam logic signed [DSP_OUT_W-1:0] SAT_MIN = {1'b1, {(DSP_OUT_W-1){1'b0}}};

    localparam logic signed [CALC_W-1:0] CALC_ONE = 1;

    // Returns {sat_flag, data}; data holds the result in its low out_w bits.
    // One guard bit above the 64-bit input keeps the rounding add from overflowing.
    function automatic logic [CALC_W-1:0] round_shift_sat(
        input logic signed [63:0] p,
        input int                 shift,
        input bit                 round,
        input bit                 sat,
        input int                 out_w
    );
        logic signed [CALC_W-1:0] r;
        logic signed [CALC_W-1:0] s;
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        logic                     flag;
        logic [63:0]              data;
        r = {p[63], p};
        if (round && shift > 0) begin
            r = r + (CALC_ONE <<< (shift - 1));
        end
        s    = r >>> shift;
        hi   = (CALC_ONE <<< (out_w - 1)) - CALC_ONE;
        lo   = -(CALC_ONE <<< (out_w - 1));
        flag = (s > hi) || (s < lo);
        data = s[63:0];
        if (sat && (s > hi)) begin
            data = hi[63:0];
        end else if (sat && (s < lo)) begin
            data = lo[63:0];
        end
        return {flag, data};
    endfunction

endpackage

// File: rtl/dsp_res_fifo.sv
// Small synchronous result FIFO with async active-low reset, synchronous flush
// and an occupancy output used by the collector's credit logic.
module dsp_res_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [W-1:0]             i_wdata,
    input  logic                     i_pop,
    output logic [W-1:0]             o_rdata,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic          w_doPush;
    logic          w_doPop;

    assign w_doPop  = i_pop & (r_level != '0);
    assign w_doPush = i_push & (r_level != LW'(DEPTH));

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_doPush) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_doPop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_level <= r_level + LW'(w_doPush) - LW'(w_doPop);
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_valid = (r_level != '0);
    assign o_level = r_level;

endmodule

// File: rtl/dsp_result_collector.sv
// Collects DSP48A1 P results after the slice's fixed latency, scales them to OUT_W bits
// and queues them behind a valid/ready port; credits keep the slice from ever stalling.
module dsp_result_collector
    import dsp_pkg::*;
#(
    parameter int P_W   = DSP_P_W,
    parameter int OUT_W = DSP_OUT_W,
    parameter int SHIFT = 0,
    parameter int ROUND = 1,
    parameter int SAT   = 1,
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    input  logic [P_W-1:0]           p_in,
    input  logic                     carryout_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_cy,
    output logic                     out_sat,
    output logic                     ovf_sticky,
    input  logic                     clr_sticky,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int FW = OUT_W + 2;

    logic [LAT-1:0]        r_vpipe;
    logic                  r_sticky;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic [31:0]           w_credit;
    logic [CALC_W-1:0]     w_calc;
    logic                  w_satFlag;
    logic [OUT_W-1:0]      w_data;
    logic [FW-1:0]         w_wdata;
    logic [FW-1:0]         w_rdata;
    logic [$clog2(DEPTH):0] w_level;

    // Every accepted operation owns a FIFO slot from issue until it is popped.
    assign w_credit = 32'(w_level) + 32'($countones(r_vpipe));
    assign in_ready = (w_credit < 32'(DEPTH));
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vpipe <= '0;
        end else if (flush) begin
            r_vpipe <= '0;
        end else begin
            r_vpipe[0] <= w_accept;
            for (int k = 1; k < LAT; k++) begin
                r_vpipe[k] <= r_vpipe[k-1];
            end
        end
    end

    assign w_push    = r_vpipe[LAT-1] & ~flush;
    assign w_calc    = round_shift_sat(64'(signed'(p_in)), SHIFT, (ROUND != 0), (SAT != 0), OUT_W);
    assign w_satFlag = w_calc[CALC_W-1];
    assign w_data    = w_calc[OUT_W-1:0];
    assign w_wdata   = {carryout_in, w_satFlag, w_data};
    assign w_pop     = out_valid & out_ready;

    dsp_res_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_flush (flush),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_valid (out_valid),
        .o_level (w_level)
    );

    // A saturating push takes priority over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
        end else if (w_push && w_satFlag) begin
            r_sticky <= 1'b1;
        end else if (clr_sticky) begin
            r_sticky <= 1'b0;
        end
    end

    assign out_cy     = w_rdata[FW-1];
    assign out_sat    = w_rdata[FW-2];
    assign out_data   = w_rdata[OUT_W-1:0];
    assign ovf_sticky = r_sticky;
    assign level      = w_level;

endmodule

// File: tb/tb_dsp_result_collector.sv
// Scoreboard bench for dsp_result_collector: two instances (round+saturate, truncate+wrap)
// share one stimulus stream emulating the slice; a monitor pops expectations on each output.
module tb_dsp_result_collector;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        carryout_in = 1'b0;
    logic        out_ready = 1'b0;
    logic        clr_sticky = 1'b0;
    logic [47:0] p_in = '0;

    logic        inReadyA, outValidA, outCyA, outSatA, stickyA;
    logic        inReadyB, outValidB, outCyB, outSatB, stickyB;
    logic [17:0] outDataA, outDataB;
    logic [2:0]  levelA, levelB;

    dsp_result_collector #(.P_W(48), .OUT_W(18), .SHIFT(4), .ROUND(1), .SAT(1), .LAT(LAT), .DEPTH(DEPTH)) dutA (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inReadyA), .flush(flush),
        .p_in(p_in), .carryout_in(carryout_in), .out_valid(outValidA), .out_ready(out_ready),
        .out_data(outDataA), .out_cy(outCyA), .out_sat(outSatA), .ovf_sticky(stickyA),
        .clr_sticky(clr_sticky), .level(levelA));

    dsp_result_collector #(.P_W(48), .OUT_W(18), .SHIFT(4), .ROUND(0), .SAT(0), .LAT(LAT), .DEPTH(DEPTH)) dutB (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(inReadyB), .flush(flush),
        .p_in(p_in), .carryout_in(carryout_in), .out_valid(outValidB), .out_ready(out_ready),
        .out_data(outDataB), .out_cy(outCyB), .out_sat(outSatB), .ovf_sticky(stickyB),
        .clr_sticky(clr_sticky), .level(levelB));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int nChecks = 0;
    int nErrors = 0;

    typedef struct {
        int          pushCyc;
        logic [17:0] dA;
        bit          sA;
        logic [17:0] dB;
        bit          sB;
        bit          cy;
    } exp_t;

    exp_t        expQ[$];
    logic [47:0] pAt[int];
    bit          cyAt[int];
    bit [1:0]    satAt[int];
    bit          expStickyA = 0;
    bit          expStickyB = 0;
    int          acceptCount = 0;

    bit          dirValid = 0;
    logic [17:0] dirA, dirB;
    bit          dirSA, dirSB;

    longint      dirP  [8] = '{24, -24, 23, 1073741824, -1073741824, 2097144, -2097152, -2097153};
    logic [17:0] dirDA [8] = '{18'h00002, 18'h3FFFF, 18'h00001, 18'h1FFFF, 18'h20000, 18'h1FFFF, 18'h20000, 18'h20000};
    bit          dirSAt[8] = '{0, 0, 0, 1, 1, 1, 0, 0};
    logic [17:0] dirDB [8] = '{18'h00001, 18'h3FFFE, 18'h00001, 18'h00000, 18'h00000, 18'h1FFFF, 18'h20000, 18'h1FFFF};
    bit          dirSBt[8] = '{0, 0, 0, 1, 1, 0, 0, 1};

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        nChecks++;
        if (act !== req) begin
            nErrors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: floor((p + half) / 16) with plain integer arithmetic, then clamp or wrap to 18 bits.
    function automatic void refModel(input longint p, input bit rnd, input bit sat,
                                     output logic [17:0] d, output bit f);
        longint r;
        longint s;
        r = p + (rnd ? 64'sd8 : 64'sd0);
        s = r >>> 4;
        f = (s > 131071) || (s < -131072);
        if (sat && s > 131071)       d = 18'h1FFFF;
        else if (sat && s < -131072) d = 18'h20000;
        else                         d = s[17:0];
    endfunction

    function automatic longint randP();
        longint x;
        case ($urandom % 4)
            0: return longint'($urandom_range(4000)) - 2000;
            1: begin
                x = ($urandom % 2) ? 64'sd2097152 : -64'sd2097152;
                return x + longint'($urandom_range(64)) - 32;
            end
            2: begin
                x = {$urandom, $urandom};
                return (x <<< 16) >>> 16;
            end
            default: return (longint'($urandom_range(20000)) - 10000) * 16 + 8;
        endcase
    endfunction

    task automatic applyStimulus(input bit v, input longint p, input bit cy, input bit fl,
                                 input bit ordy, input bit clr);
        int          c;
        int          pend;
        exp_t        e;
        logic [63:0] g;
        @(posedge clk);
        #1;
        c = cyc;
        in_valid    = v;
        flush       = fl;
        out_ready   = ordy && !fl;
        clr_sticky  = clr;
        g           = {$urandom, $urandom};
        p_in        = pAt.exists(c) ? pAt[c] : g[47:0];
        carryout_in = cyAt.exists(c) ? cyAt[c] : g[48];
        #3;
        pend = 0;
        foreach (expQ[i]) if (expQ[i].pushCyc < c) pend++;
        checkOutput("in_ready_a", inReadyA, expQ.size() < DEPTH);
        checkOutput("in_ready_b", inReadyB, expQ.size() < DEPTH);
        checkOutput("level_a", levelA, pend);
        checkOutput("level_b", levelB, pend);
        checkOutput("sticky_a", stickyA, expStickyA);
        checkOutput("sticky_b", stickyB, expStickyB);
        if (fl) begin
            expQ.delete();
            for (int k = c; k < c + LAT; k++) begin
                pAt.delete(k);
                cyAt.delete(k);
                satAt.delete(k);
            end
        end
        if (v && inReadyA && !fl) begin
            acceptCount++;
            pAt[c+LAT]  = p[47:0];
            cyAt[c+LAT] = cy;
            e.pushCyc   = c + LAT;
            e.cy        = cy;
            if (dirValid) begin
                e.dA = dirA; e.sA = dirSA; e.dB = dirB; e.sB = dirSB;
            end else begin
                refModel(p, 1'b1, 1'b1, e.dA, e.sA);
                refModel(p, 1'b0, 1'b0, e.dB, e.sB);
            end
            satAt[c+LAT] = {e.sA, e.sB};
            expQ.push_back(e);
        end
        if (satAt.exists(c) && satAt[c][1]) expStickyA = 1'b1;
        else if (clr)                       expStickyA = 1'b0;
        if (satAt.exists(c) && satAt[c][0]) expStickyB = 1'b1;
        else if (clr)                       expStickyB = 1'b0;
    endtask

    task automatic idle(input bit ordy);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, ordy, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && expQ.size() > 0; i++) idle(1'b1);
        idle(1'b1);
        checkOutput("drain_level_a", levelA, 0);
        checkOutput("drain_valid_a", outValidA, 0);
    endtask

    task automatic asyncReset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
        #1;
        checkOutput("rst_in_ready", inReadyA, 1);
        checkOutput("rst_out_valid", outValidA, 0);
        checkOutput("rst_level", levelA, 0);
        checkOutput("rst_out_data", outDataA, 0);
        checkOutput("rst_out_cy", outCyA, 0);
        checkOutput("rst_out_sat", outSatA, 0);
        checkOutput("rst_sticky", stickyA, 0);
        checkOutput("rst_out_valid_b", outValidB, 0);
        expQ.delete(); pAt.delete(); cyAt.delete(); satAt.delete();
        expStickyA = 1'b0;
        expStickyB = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: whenever an output is due or presented, compare the head and pop on handshake.
    always @(negedge clk) begin
        bit due;
        if (rst_n && !flush) begin
            due = (expQ.size() > 0) && (expQ[0].pushCyc < cyc);
            if (outValidA || outValidB || due) begin
                checkOutput("out_valid_a", outValidA, due);
                checkOutput("out_valid_b", outValidB, due);
                if (due && outValidA) begin
                    checkOutput("out_data_a", outDataA, expQ[0].dA);
                    checkOutput("out_sat_a", outSatA, expQ[0].sA);
                    checkOutput("out_cy_a", outCyA, expQ[0].cy);
                    checkOutput("out_data_b", outDataB, expQ[0].dB);
                    checkOutput("out_sat_b", outSatB, expQ[0].sB);
                    checkOutput("out_cy_b", outCyB, expQ[0].cy);
                    if (out_ready) void'(expQ.pop_front());
                end
            end
        end
    end

    initial begin
        #200us;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", inReadyA, 1);
        checkOutput("reset_out_valid", outValidA, 0);
        checkOutput("reset_level", levelA, 0);
        checkOutput("reset_out_data", outDataA, 0);
        checkOutput("reset_sticky", stickyA, 0);
        #1;
        rst_n = 1'b1;

        $display("[TB] latency: single issue");
        dirValid = 1; dirA = 18'h00123; dirSA = 0; dirB = 18'h00123; dirSB = 0;
        applyStimulus(1'b1, 64'h1234, 1'b1, 1'b0, 1'b1, 1'b0);
        dirValid = 0;
        repeat (5) idle(1'b1);

        $display("[TB] rounding and saturation table");
        for (int i = 0; i < 8; i++) begin
            dirValid = 1; dirA = dirDA[i]; dirSA = dirSAt[i]; dirB = dirDB[i]; dirSB = dirSBt[i];
            applyStimulus(1'b1, dirP[i], i[0], 1'b0, 1'b1, 1'b0);
        end
        dirValid = 0;
        drain();
        checkOutput("t3_sticky_a", stickyA, 1);
        checkOutput("t3_sticky_b", stickyB, 1);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        checkOutput("sticky_cleared", stickyA, 0);

        $display("[TB] backpressure");
        acceptCount = 0;
        repeat (8) applyStimulus(1'b1, randP(), 1'($urandom), 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        checkOutput("t4_accepts", acceptCount, 4);
        checkOutput("t4_in_ready", inReadyA, 0);
        checkOutput("t4_level", levelA, 4);
        drain();

        $display("[TB] flush");
        applyStimulus(1'b1, randP(), 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, randP(), 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        applyStimulus(1'b1, randP(), 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, randP(), 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        checkOutput("t5_level", levelA, 0);
        checkOutput("t5_out_valid", outValidA, 0);
        checkOutput("t5_in_ready", inReadyA, 1);
        repeat (4) idle(1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom % 4) != 0, randP(), 1'($urandom), ($urandom % 64) == 0,
                          ($urandom % 3) != 0, ($urandom % 16) == 0);
        end

        $display("[TB] async reset mid-stream");
        applyStimulus(1'b1, 64'h1234, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, randP(), 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        asyncReset();
        dirValid = 1; dirA = 18'h00123; dirSA = 0; dirB = 18'h00123; dirSB = 0;
        applyStimulus(1'b1, 64'h1234, 1'b0, 1'b0, 1'b1, 1'b0);
        dirValid = 0;
        repeat (5) idle(1'b1);

        $display("[TB] sticky set and clear together");
        applyStimulus(1'b1, 64'sd1073741824, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        checkOutput("sticky_set_wins", stickyA, 1);
        drain();

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
